// File: rtl/usb_rx_controller_if.sv
// Bit-level receive bus: sampled line inputs from the clock-recovery stage,
// byte and status outputs toward the packet layer.
interface usb_rx_controller_if;
    logic       bit_strobe;
    logic       raw_bit;
    logic       se0;
    logic       dec_bit;
    logic       nrzi_en;
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic [6:0] byte_cnt;
    logic       pkt_active;
    logic       pkt_end;
    logic       rx_err;
    logic [1:0] err_code;

    modport master (
        output bit_strobe, raw_bit, se0, dec_bit,
        input  nrzi_en, rx_byte, byte_valid, byte_cnt,
        input  pkt_active, pkt_end, rx_err, err_code
    );

    modport slave (
        input  bit_strobe, raw_bit, se0, dec_bit,
        output nrzi_en, rx_byte, byte_valid, byte_cnt,
        output pkt_active, pkt_end, rx_err, err_code
    );
endinterface

// File: rtl/usb_rx_controller.sv
// USB receive sequencer: SYNC detect, bit unstuffing, LSB-first byte assembly,
// EOP detect and error reporting. Advances only on bit_strobe.
module usb_rx_controller #(
    parameter int SYNC_MIN_ZEROS = 5,
    parameter int MAX_BYTES      = 67
) (
    input  logic                clk,
    input  logic                nRST,
    usb_rx_controller_if.slave  bus
);
    localparam logic [2:0] L_MIN_ZEROS = 3'(SYNC_MIN_ZEROS);
    localparam logic [6:0] L_MAX_BYTES = 7'(MAX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_DATA, S_EOP, S_WAIT_IDLE
    } state_t;

    state_t     r_state;
    logic [2:0] r_zero_cnt;
    logic [2:0] r_ones_cnt;
    logic [2:0] r_bit_cnt;
    logic [2:0] r_j_cnt;
    logic       r_last_se0;
    logic [7:0] r_shift;
    logic       r_nrzi_en;
    logic [7:0] r_rx_byte;
    logic       r_byte_valid;
    logic [6:0] r_byte_cnt;
    logic       r_pkt_active;
    logic       r_pkt_end;
    logic       r_rx_err;
    logic [1:0] r_err_code;

    logic       w_j;
    logic       w_k;
    logic [7:0] w_shift_next;

    assign w_j          = !bus.se0 && bus.raw_bit;
    assign w_k          = !bus.se0 && !bus.raw_bit;
    assign w_shift_next = {bus.dec_bit, r_shift[7:1]};

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    // Any error drops the packet and parks the FSM until the line is idle again.
    task automatic raise_err(input logic [1:0] code);
        r_rx_err     <= 1'b1;
        r_err_code   <= code;
        r_pkt_active <= 1'b0;
        r_nrzi_en    <= 1'b0;
        r_j_cnt      <= 3'd0;
        r_state      <= S_WAIT_IDLE;
    endtask

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state      <= S_IDLE;
            r_zero_cnt   <= 3'd0;
            r_ones_cnt   <= 3'd0;
            r_bit_cnt    <= 3'd0;
            r_j_cnt      <= 3'd0;
            r_last_se0   <= 1'b0;
            r_shift      <= 8'd0;
            r_nrzi_en    <= 1'b0;
            r_rx_byte    <= 8'd0;
            r_byte_valid <= 1'b0;
            r_byte_cnt   <= 7'd0;
            r_pkt_active <= 1'b0;
            r_pkt_end    <= 1'b0;
            r_rx_err     <= 1'b0;
            r_err_code   <= 2'd0;
        end else begin
            r_byte_valid <= 1'b0;
            r_pkt_end    <= 1'b0;
            r_rx_err     <= 1'b0;
            if (bus.bit_strobe) begin
                r_last_se0 <= bus.se0;
                case (r_state)
                    S_IDLE: begin
                        if (w_k) begin
                            r_nrzi_en  <= 1'b1;
                            r_zero_cnt <= 3'd1;
                            r_state    <= S_SYNC;
                        end
                    end
                    S_SYNC: begin
                        if (bus.se0 || (bus.dec_bit && r_zero_cnt < L_MIN_ZEROS)) begin
                            raise_err(2'd1);
                        end else if (bus.dec_bit) begin
                            r_pkt_active <= 1'b1;
                            r_ones_cnt   <= 3'd1;
                            r_bit_cnt    <= 3'd0;
                            r_byte_cnt   <= 7'd0;
                            r_state      <= S_DATA;
                        end else begin
                            r_zero_cnt <= sat_inc3(r_zero_cnt);
                        end
                    end
                    S_DATA: begin
                        if (bus.se0) begin
                            if (r_bit_cnt != 3'd0) raise_err(2'd3);
                            else                   r_state <= S_EOP;
                        end else if (r_ones_cnt == 3'd6) begin
                            // Stuffed-bit slot: must be a 0 and is discarded.
                            if (bus.dec_bit) raise_err(2'd2);
                            else             r_ones_cnt <= 3'd0;
                        end else begin
                            r_shift    <= w_shift_next;
                            r_ones_cnt <= bus.dec_bit ? r_ones_cnt + 3'd1 : 3'd0;
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt <= 3'd0;
                                if (r_byte_cnt == L_MAX_BYTES) begin
                                    raise_err(2'd3);
                                end else begin
                                    r_rx_byte    <= w_shift_next;
                                    r_byte_valid <= 1'b1;
                                    r_byte_cnt   <= r_byte_cnt + 7'd1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    S_EOP: begin
                        if (!bus.se0) begin
                            if (bus.raw_bit) begin
                                r_pkt_end    <= 1'b1;
                                r_pkt_active <= 1'b0;
                                r_nrzi_en    <= 1'b0;
                                r_state      <= S_IDLE;
                            end else begin
                                raise_err(2'd3);
                            end
                        end
                    end
                    S_WAIT_IDLE: begin
                        // A J right after SE0 is a proper EOP; otherwise require a long idle run.
                        if (w_j) begin
                            if (r_last_se0 || r_j_cnt == 3'd6) begin
                                r_j_cnt <= 3'd0;
                                r_state <= S_IDLE;
                            end else begin
                                r_j_cnt <= r_j_cnt + 3'd1;
                            end
                        end else begin
                            r_j_cnt <= 3'd0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.nrzi_en    = r_nrzi_en;
    assign bus.rx_byte    = r_rx_byte;
    assign bus.byte_valid = r_byte_valid;
    assign bus.byte_cnt   = r_byte_cnt;
    assign bus.pkt_active = r_pkt_active;
    assign bus.pkt_end    = r_pkt_end;
    assign bus.rx_err     = r_rx_err;
    assign bus.err_code   = r_err_code;
endmodule

// File: tb/tb_usb_rx_controller.sv
// Directed bench for usb_rx_controller: drives NRZI-consistent line samples
// with matching decoded bits and checks bytes, pulses and error codes.
module tb_usb_rx_controller;
    logic clk = 1'b0;
    logic nRST;
    logic line;

    int n_pass  = 0;
    int n_total = 0;
    int cnt_bv  = 0;
    int cnt_end = 0;
    int cnt_err = 0;
    logic [7:0] byte_log [0:255];

    usb_rx_controller_if bus ();

    usb_rx_controller #(.SYNC_MIN_ZEROS(5), .MAX_BYTES(67)) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Pulse monitor: pulses last one full cycle, so each is seen on exactly one negedge.
    always @(negedge clk) begin
        if (bus.byte_valid === 1'b1) begin
            byte_log[cnt_bv[7:0]] <= bus.rx_byte;
            cnt_bv <= cnt_bv + 1;
        end
        if (bus.pkt_end === 1'b1) cnt_end <= cnt_end + 1;
        if (bus.rx_err === 1'b1)  cnt_err <= cnt_err + 1;
    end

    task automatic send(input logic raw, input logic s0, input logic d);
        @(negedge clk);
        bus.bit_strobe = 1'b1;
        bus.raw_bit    = raw;
        bus.se0        = s0;
        bus.dec_bit    = d;
    endtask

    task automatic send_dec(input logic d);
        if (!d) line = ~line;
        send(line, 1'b0, d);
    endtask

    task automatic send_j();
        line = 1'b1;
        send(1'b1, 1'b0, 1'b1);
    endtask

    task automatic send_se0();
        send(1'b0, 1'b1, 1'b0);
    endtask

    task automatic send_sync();
        line = 1'b1;
        repeat (7) send_dec(1'b0);
        send_dec(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_dec(b[i]);
    endtask

    task automatic send_eop();
        send_se0();
        send_se0();
        send_j();
    endtask

    task automatic gap();
        @(negedge clk);
        bus.bit_strobe = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_total++;
        if ({bus.nrzi_en, bus.rx_byte, bus.byte_valid, bus.byte_cnt, bus.pkt_active,
             bus.pkt_end, bus.rx_err, bus.err_code} !== 22'd0)
            $display("FAIL reset_outputs: got nrzi=%b byte=%h bv=%b cnt=%0d act=%b end=%b err=%b code=%0d, want all 0",
                     bus.nrzi_en, bus.rx_byte, bus.byte_valid, bus.byte_cnt, bus.pkt_active,
                     bus.pkt_end, bus.rx_err, bus.err_code);
        else n_pass++;
        @(negedge clk);
        nRST = 1'b1;
        gap();
    endtask

    task automatic test_basic();
        int bv0, end0, err0;
        bv0 = cnt_bv; end0 = cnt_end; err0 = cnt_err;
        send_j(); send_j(); gap();
        n_total++;
        if (bus.nrzi_en !== 1'b0) $display("FAIL basic_idle_nrzi: got %b want 0", bus.nrzi_en); else n_pass++;
        send_sync(); gap();
        n_total++;
        if (bus.pkt_active !== 1'b1 || bus.nrzi_en !== 1'b1)
            $display("FAIL basic_sync: got act=%b nrzi=%b want 1 1", bus.pkt_active, bus.nrzi_en);
        else n_pass++;
        send_byte(8'hA5); gap();
        n_total++;
        if (cnt_bv - bv0 != 1 || byte_log[bv0[7:0]] !== 8'hA5)
            $display("FAIL basic_byte: got %0d bytes first=%h want 1 bytes a5", cnt_bv - bv0, byte_log[bv0[7:0]]);
        else n_pass++;
        n_total++;
        if (bus.byte_cnt !== 7'd1) $display("FAIL basic_byte_cnt: got %0d want 1", bus.byte_cnt); else n_pass++;
        send_eop(); gap();
        n_total++;
        if (bus.pkt_end !== 1'b1 || bus.pkt_active !== 1'b0)
            $display("FAIL basic_pkt_end: got end=%b act=%b want 1 0", bus.pkt_end, bus.pkt_active);
        else n_pass++;
        gap();
        n_total++;
        if (bus.pkt_end !== 1'b0 || bus.nrzi_en !== 1'b0 || cnt_end - end0 != 1 || cnt_err != err0)
            $display("FAIL basic_after_eop: got end=%b nrzi=%b ends=%0d errs=%0d want 0 0 1 0",
                     bus.pkt_end, bus.nrzi_en, cnt_end - end0, cnt_err - err0);
        else n_pass++;
    endtask

    task automatic test_stuffing();
        int bv0, end0, err0;
        bv0 = cnt_bv; end0 = cnt_end; err0 = cnt_err;
        send_j(); send_sync();
        repeat (5) send_dec(1'b1);
        send_dec(1'b0);
        repeat (3) send_dec(1'b1);
        send_byte(8'h00);
        send_eop(); gap();
        n_total++;
        if (cnt_bv - bv0 != 2 || byte_log[bv0[7:0]] !== 8'hFF || byte_log[8'(bv0 + 1)] !== 8'h00)
            $display("FAIL stuff_bytes: got %0d bytes %h %h want 2 bytes ff 00",
                     cnt_bv - bv0, byte_log[bv0[7:0]], byte_log[8'(bv0 + 1)]);
        else n_pass++;
        n_total++;
        if (cnt_err != err0 || cnt_end - end0 != 1 || bus.byte_cnt !== 7'd2)
            $display("FAIL stuff_status: got errs=%0d ends=%0d cnt=%0d want 0 1 2",
                     cnt_err - err0, cnt_end - end0, bus.byte_cnt);
        else n_pass++;
    endtask

    task automatic test_stuff_err();
        send_j(); send_sync();
        repeat (6) send_dec(1'b1);
        gap();
        n_total++;
        if (bus.rx_err !== 1'b1 || bus.err_code !== 2'd2 || bus.pkt_active !== 1'b0 || bus.nrzi_en !== 1'b0)
            $display("FAIL stuff_err: got err=%b code=%0d act=%b nrzi=%b want 1 2 0 0",
                     bus.rx_err, bus.err_code, bus.pkt_active, bus.nrzi_en);
        else n_pass++;
        send_dec(1'b1);
        send_se0(); send_j();
        send_sync(); gap();
        n_total++;
        if (bus.pkt_active !== 1'b1 || bus.err_code !== 2'd2)
            $display("FAIL stuff_err_recover: got act=%b code=%0d want 1 2", bus.pkt_active, bus.err_code);
        else n_pass++;
        send_eop(); gap();
    endtask

    task automatic test_short_sync();
        int bv0;
        bv0 = cnt_bv;
        send_j();
        line = 1'b1;
        send_dec(1'b0); send_dec(1'b0); send_dec(1'b0); send_dec(1'b1);
        gap();
        n_total++;
        if (bus.rx_err !== 1'b1 || bus.err_code !== 2'd1 || cnt_bv != bv0 || bus.pkt_active !== 1'b0)
            $display("FAIL short_sync: got err=%b code=%0d bytes=%0d act=%b want 1 1 0 0",
                     bus.rx_err, bus.err_code, cnt_bv - bv0, bus.pkt_active);
        else n_pass++;
        send_se0(); send_j(); gap();
    endtask

    task automatic test_align_err();
        int bv0, end0;
        bv0 = cnt_bv; end0 = cnt_end;
        send_j(); send_sync();
        send_byte(8'h3C);
        send_dec(1'b1); send_dec(1'b0); send_dec(1'b1);
        send_se0(); gap();
        n_total++;
        if (bus.rx_err !== 1'b1 || bus.err_code !== 2'd3)
            $display("FAIL align_err: got err=%b code=%0d want 1 3", bus.rx_err, bus.err_code);
        else n_pass++;
        n_total++;
        if (cnt_bv - bv0 != 1 || byte_log[bv0[7:0]] !== 8'h3C || cnt_end != end0)
            $display("FAIL align_bytes: got %0d bytes %h ends=%0d want 1 3c 0",
                     cnt_bv - bv0, byte_log[bv0[7:0]], cnt_end - end0);
        else n_pass++;
        send_j(); gap();
    endtask

    task automatic test_overflow();
        int bv0, end0;
        logic [7:0] b;
        bv0 = cnt_bv; end0 = cnt_end;
        send_j(); send_sync();
        for (int i = 0; i < 68; i++) begin
            b = 8'(i * 5) & 8'h77;
            send_byte(b);
        end
        gap();
        n_total++;
        if (bus.rx_err !== 1'b1 || bus.err_code !== 2'd3 || bus.pkt_active !== 1'b0)
            $display("FAIL overflow_err: got err=%b code=%0d act=%b want 1 3 0",
                     bus.rx_err, bus.err_code, bus.pkt_active);
        else n_pass++;
        n_total++;
        if (cnt_bv - bv0 != 67 || bus.byte_cnt !== 7'd67 || cnt_end != end0)
            $display("FAIL overflow_count: got pulses=%0d cnt=%0d ends=%0d want 67 67 0",
                     cnt_bv - bv0, bus.byte_cnt, cnt_end - end0);
        else n_pass++;
        n_total++;
        if (byte_log[bv0[7:0]] !== 8'h00 || byte_log[8'(bv0 + 66)] !== 8'h42)
            $display("FAIL overflow_data: got first=%h last=%h want 00 42",
                     byte_log[bv0[7:0]], byte_log[8'(bv0 + 66)]);
        else n_pass++;
        send_se0(); send_j(); gap();
    endtask

    task automatic test_reset_mid();
        int bv0, end0, err0;
        send_j(); send_sync();
        send_dec(1'b1); send_dec(1'b0); send_dec(1'b1); send_dec(1'b0);
        gap();
        n_total++;
        if (bus.pkt_active !== 1'b1) $display("FAIL rst_mid_pre: got act=%b want 1", bus.pkt_active); else n_pass++;
        bv0 = cnt_bv; end0 = cnt_end; err0 = cnt_err;
        #2 nRST = 1'b0;
        #1;
        n_total++;
        if ({bus.nrzi_en, bus.rx_byte, bus.byte_valid, bus.byte_cnt, bus.pkt_active,
             bus.pkt_end, bus.rx_err, bus.err_code} !== 22'd0)
            $display("FAIL rst_mid_clear: got nrzi=%b byte=%h cnt=%0d act=%b code=%0d want all 0",
                     bus.nrzi_en, bus.rx_byte, bus.byte_cnt, bus.pkt_active, bus.err_code);
        else n_pass++;
        send_dec(1'b1); send_dec(1'b1);
        gap();
        nRST = 1'b1;
        gap(); gap();
        n_total++;
        if (cnt_bv != bv0 || cnt_end != end0 || cnt_err != err0)
            $display("FAIL rst_mid_pulses: got bv=%0d end=%0d err=%0d want 0 0 0",
                     cnt_bv - bv0, cnt_end - end0, cnt_err - err0);
        else n_pass++;
        send_j(); send_sync();
        send_byte(8'hC3);
        send_eop(); gap();
        n_total++;
        if (cnt_bv - bv0 != 1 || byte_log[bv0[7:0]] !== 8'hC3 || bus.pkt_end !== 1'b1 || cnt_err != err0)
            $display("FAIL rst_mid_next_pkt: got bytes=%0d byte=%h end=%b errs=%0d want 1 c3 1 0",
                     cnt_bv - bv0, byte_log[bv0[7:0]], bus.pkt_end, cnt_err - err0);
        else n_pass++;
        n_total++;
        if (bus.byte_cnt !== 7'd1) $display("FAIL rst_mid_byte_cnt: got %0d want 1", bus.byte_cnt); else n_pass++;
    endtask

    initial begin
        bus.bit_strobe = 1'b0;
        bus.raw_bit    = 1'b1;
        bus.se0        = 1'b0;
        bus.dec_bit    = 1'b1;
        line           = 1'b1;
        test_reset();
        test_basic();
        test_stuffing();
        test_stuff_err();
        test_short_sync();
        test_align_err();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
